// File: rtl/uart_pkg.sv
// Frame-configuration encodings and FSM state shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK_WAIT
    } uart_state_e;

    localparam logic [2:0] DATA_BITS_5 = 3'd0;
    localparam logic [2:0] DATA_BITS_6 = 3'd1;
    localparam logic [2:0] DATA_BITS_7 = 3'd2;
    localparam logic [2:0] DATA_BITS_8 = 3'd3;
    localparam logic [2:0] DATA_BITS_9 = 3'd4;

    localparam logic PARITY_EVEN = 1'b1;
    localparam logic PARITY_ODD  = 1'b0;
    localparam logic STOP_BITS_1 = 1'b0;
    localparam logic STOP_BITS_2 = 1'b1;

    // Unassigned codes fall back to the common 8-bit frame.
    function automatic logic [3:0] num_data_bits(input logic [2:0] code);
        case (code)
            DATA_BITS_5: return 4'd5;
            DATA_BITS_6: return 4'd6;
            DATA_BITS_7: return 4'd7;
            DATA_BITS_8: return 4'd8;
            DATA_BITS_9: return 4'd9;
            default:     return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX input synchronizer, oversample tick counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic rx_i,
    input  logic hold_i,
    output logic rx_sync_o,
    output logic bit_o,
    output logic mid_o,
    output logic wrap_o
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] TC_LO   = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] TC_HI   = TCW'(OVERSAMPLE / 2 + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TCW-1:0]         tc_q, tc_d;
    logic                   s_lo_q, s_lo_d;
    logic                   s_mid_q, s_mid_d;
    logic                   rx_sync;

    assign rx_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = rx_i;
    end

    // Counter is parked at zero while idle so the start edge defines bit phase.
    always_comb begin
        tc_d    = tc_q;
        s_lo_d  = s_lo_q;
        s_mid_d = s_mid_q;
        if (hold_i) begin
            tc_d = '0;
        end else if (tick_i) begin
            tc_d = tc_q + 1'b1;
            if (tc_q == TC_LO)  s_lo_d  = rx_sync;
            if (tc_q == TC_MID) s_mid_d = rx_sync;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            tc_q    <= '0;
            s_lo_q  <= 1'b1;
            s_mid_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            tc_q    <= tc_d;
            s_lo_q  <= s_lo_d;
            s_mid_q <= s_mid_d;
        end
    end

    assign rx_sync_o = rx_sync;
    assign mid_o     = tick_i & ~hold_i & (tc_q == TC_HI);
    assign wrap_o    = tick_i & ~hold_i & (tc_q == TC_LAST);
    assign bit_o     = (s_lo_q & s_mid_q) | (s_lo_q & rx_sync) | (s_mid_q & rx_sync);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: frame FSM, error detection and one-deep host holding register.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Sample_Tick_In,
    input  logic       UART_RX,
    input  logic [2:0] UART_Num_Data_Bits_In,
    input  logic       UART_Parity_Enable_In,
    input  logic       UART_Even_Oddb_Parity_In,
    input  logic       UART_Num_Stop_Bits_In,
    input  logic       Data_Read_In,
    output logic [8:0] Data_Out,
    output logic       Data_Valid_Out,
    output logic       Parity_Error_Out,
    output logic       Framing_Error_Out,
    output logic       Overrun_Error_Out,
    output logic       Break_Detect_Out,
    output logic       RX_Busy_Indicator
);

    uart_state_e state_q;

    logic       rx_sync, vote, mid, wrap;
    logic [3:0] ndata_q;
    logic       par_en_q, even_q, two_stop_q;
    logic [3:0] bitcnt_q;
    logic [8:0] shift_q;
    logic       pbit_q;
    logic       allzero_q;
    logic       stop1_err_q;

    logic       frame_done, frame_brk, frame_ferr, frame_perr, par_sum;
    logic [8:0] frame_data;

    logic [8:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       brk_q, brk_d;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk_i    (Clk_In),
        .rst_ni   (Reset_In),
        .tick_i   (Sample_Tick_In),
        .rx_i     (UART_RX),
        .hold_i   (state_q == ST_IDLE),
        .rx_sync_o(rx_sync),
        .bit_o    (vote),
        .mid_o    (mid),
        .wrap_o   (wrap)
    );

    // Frame completes at the mid-bit vote of the final stop bit.
    always_comb begin
        frame_done = mid & (((state_q == ST_STOP1) & ~two_stop_q) | (state_q == ST_STOP2));
        frame_brk  = allzero_q & ~vote;
        frame_ferr = stop1_err_q | ~vote;
        par_sum    = (^shift_q) ^ pbit_q;
        frame_perr = par_en_q & (even_q ? par_sum : ~par_sum);
        frame_data = frame_brk ? 9'd0 : shift_q;
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q     <= ST_IDLE;
            ndata_q     <= 4'd8;
            par_en_q    <= 1'b0;
            even_q      <= 1'b0;
            two_stop_q  <= 1'b0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            pbit_q      <= 1'b0;
            allzero_q   <= 1'b0;
            stop1_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Sample_Tick_In && !rx_sync) begin
                        state_q     <= ST_START;
                        ndata_q     <= num_data_bits(UART_Num_Data_Bits_In);
                        par_en_q    <= UART_Parity_Enable_In;
                        even_q      <= (UART_Even_Oddb_Parity_In == PARITY_EVEN);
                        two_stop_q  <= (UART_Num_Stop_Bits_In == STOP_BITS_2);
                        bitcnt_q    <= '0;
                        shift_q     <= '0;
                        pbit_q      <= 1'b0;
                        allzero_q   <= 1'b1;
                        stop1_err_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (mid && vote) begin
                        state_q <= ST_IDLE;
                    end else if (wrap) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shift_q[bitcnt_q] <= vote;
                        bitcnt_q          <= bitcnt_q + 4'd1;
                        if (vote) allzero_q <= 1'b0;
                    end
                    if (wrap && bitcnt_q == ndata_q) begin
                        state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    if (mid) begin
                        pbit_q <= vote;
                        if (vote) allzero_q <= 1'b0;
                    end
                    if (wrap) state_q <= ST_STOP1;
                end
                ST_STOP1: begin
                    if (frame_done) begin
                        state_q <= frame_brk ? ST_BREAK_WAIT : ST_IDLE;
                    end else begin
                        if (mid) begin
                            stop1_err_q <= ~vote;
                            if (vote) allzero_q <= 1'b0;
                        end
                        if (wrap) state_q <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (frame_done) state_q <= frame_brk ? ST_BREAK_WAIT : ST_IDLE;
                end
                ST_BREAK_WAIT: begin
                    if (Sample_Tick_In && rx_sync) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A read in the same cycle as a completion frees the slot, so no overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        brk_d   = brk_q;
        if (frame_done) begin
            if (valid_q && !Data_Read_In) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = frame_data;
                perr_d  = frame_perr;
                ferr_d  = frame_ferr;
                brk_d   = frame_brk;
                valid_d = 1'b1;
                if (Data_Read_In) ovr_d = 1'b0;
            end
        end else if (Data_Read_In) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    assign Data_Out          = data_q;
    assign Data_Valid_Out    = valid_q;
    assign Parity_Error_Out  = perr_q;
    assign Framing_Error_Out = ferr_q;
    assign Overrun_Error_Out = ovr_q;
    assign Break_Detect_Out  = brk_q;
    assign RX_Busy_Indicator = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled with a queue of expected received words.
module tb_uart_rx_oversampled;

    logic       Clk_In = 1'b0;
    logic       Reset_In;
    logic       Sample_Tick_In;
    logic       UART_RX;
    logic [2:0] UART_Num_Data_Bits_In;
    logic       UART_Parity_Enable_In;
    logic       UART_Even_Oddb_Parity_In;
    logic       UART_Num_Stop_Bits_In;
    logic       Data_Read_In;
    logic [8:0] Data_Out;
    logic       Data_Valid_Out;
    logic       Parity_Error_Out;
    logic       Framing_Error_Out;
    logic       Overrun_Error_Out;
    logic       Break_Detect_Out;
    logic       RX_Busy_Indicator;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx_oversampled #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .Clk_In                  (Clk_In),
        .Reset_In                (Reset_In),
        .Sample_Tick_In          (Sample_Tick_In),
        .UART_RX                 (UART_RX),
        .UART_Num_Data_Bits_In   (UART_Num_Data_Bits_In),
        .UART_Parity_Enable_In   (UART_Parity_Enable_In),
        .UART_Even_Oddb_Parity_In(UART_Even_Oddb_Parity_In),
        .UART_Num_Stop_Bits_In   (UART_Num_Stop_Bits_In),
        .Data_Read_In            (Data_Read_In),
        .Data_Out                (Data_Out),
        .Data_Valid_Out          (Data_Valid_Out),
        .Parity_Error_Out        (Parity_Error_Out),
        .Framing_Error_Out       (Framing_Error_Out),
        .Overrun_Error_Out       (Overrun_Error_Out),
        .Break_Detect_Out        (Break_Detect_Out),
        .RX_Busy_Indicator       (RX_Busy_Indicator)
    );

    always #5 Clk_In = ~Clk_In;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk_In);
            #1;
        end
    endtask

    task automatic read_pulse();
        Data_Read_In = 1'b1;
        cyc(1);
        Data_Read_In = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit flip);
        for (int i = 0; i < 16; i++) begin
            UART_RX = (flip && i == 9) ? ~b : b;
            cyc(1);
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int n, input bit pe, input bit ev,
                              input bit two, input bit bad_par, input bit stop2_low,
                              input int flip_bit);
        logic [8:0] m;
        logic       pb;
        exp_t       e;
        m  = d & ~(9'h1FF << n);
        pb = ev ? ^m : ~(^m);
        if (bad_par) pb = ~pb;
        UART_Num_Data_Bits_In    = 3'(n - 5);
        UART_Parity_Enable_In    = pe;
        UART_Even_Oddb_Parity_In = ev;
        UART_Num_Stop_Bits_In    = two;
        e.data = m;
        e.perr = pe & bad_par;
        e.ferr = two & stop2_low;
        e.brk  = 1'b0;
        exp_q.push_back(e);
        send_bit(1'b0, 0);
        for (int i = 0; i < n; i++) send_bit(m[i], i == flip_bit);
        if (pe) send_bit(pb, 0);
        send_bit(1'b1, 0);
        if (two) send_bit(~stop2_low, 0);
        UART_RX = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        int   k;
        exp_t e;
        k = 0;
        while (Data_Valid_Out !== 1'b1 && k < 100) begin
            cyc(1);
            k++;
        end
        check({tag, "_valid"}, 16'(Data_Valid_Out), 16'd1);
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 16'(Data_Out), 16'(e.data));
            check({tag, "_perr"}, 16'(Parity_Error_Out), 16'(e.perr));
            check({tag, "_ferr"}, 16'(Framing_Error_Out), 16'(e.ferr));
            check({tag, "_brk"}, 16'(Break_Detect_Out), 16'(e.brk));
        end
    endtask

    initial begin
        exp_t brk_e;
        Reset_In                 = 1'b0;
        Sample_Tick_In           = 1'b1;
        UART_RX                  = 1'b1;
        Data_Read_In             = 1'b0;
        UART_Num_Data_Bits_In    = 3'd3;
        UART_Parity_Enable_In    = 1'b0;
        UART_Even_Oddb_Parity_In = 1'b1;
        UART_Num_Stop_Bits_In    = 1'b0;
        cyc(3);
        check("rst_valid", 16'(Data_Valid_Out), 16'd0);
        check("rst_data", 16'(Data_Out), 16'd0);
        check("rst_busy", 16'(RX_Busy_Indicator), 16'd0);
        check("rst_ovr", 16'(Overrun_Error_Out), 16'd0);
        Reset_In = 1'b1;
        cyc(3);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 0, 1, 0, 0, 0, -1);
        check_rx("8n1");
        check("8n1_ovr", 16'(Overrun_Error_Out), 16'd0);
        check("8n1_busy", 16'(RX_Busy_Indicator), 16'd0);
        read_pulse();
        check("8n1_read_valid", 16'(Data_Valid_Out), 16'd0);

        // 9E1 with good and bad parity
        send_frame(9'h1C3, 9, 1, 1, 0, 0, 0, -1);
        check_rx("9e1_ok");
        read_pulse();
        send_frame(9'h1C3, 9, 1, 1, 0, 1, 0, -1);
        check_rx("9e1_bad");
        read_pulse();

        // 7O2 with the second stop bit low
        send_frame(9'h055, 7, 1, 0, 1, 0, 1, -1);
        check_rx("7o2_ferr");
        cyc(40);
        read_pulse();

        // Short low glitch on idle line
        UART_RX = 1'b0;
        cyc(5);
        UART_RX = 1'b1;
        cyc(30);
        check("glitch_valid", 16'(Data_Valid_Out), 16'd0);
        check("glitch_busy", 16'(RX_Busy_Indicator), 16'd0);

        // Single-sample flip inside data bit 3
        send_frame(9'h096, 8, 0, 1, 0, 0, 0, 3);
        check_rx("flip");
        read_pulse();

        // Back-to-back frames without reading: second is dropped
        send_frame(9'h011, 8, 0, 1, 0, 0, 0, -1);
        send_frame(9'h022, 8, 0, 1, 0, 0, 0, -1);
        check_rx("ovr_first");
        void'(exp_q.pop_front());
        check("ovr_flag", 16'(Overrun_Error_Out), 16'd1);
        read_pulse();
        check("ovr_read_valid", 16'(Data_Valid_Out), 16'd0);
        check("ovr_read_flag", 16'(Overrun_Error_Out), 16'd0);

        // Break: line low for 12 bit times
        UART_Num_Data_Bits_In = 3'd3;
        UART_Parity_Enable_In = 1'b0;
        UART_Num_Stop_Bits_In = 1'b0;
        brk_e.data = 9'd0;
        brk_e.perr = 1'b0;
        brk_e.ferr = 1'b1;
        brk_e.brk  = 1'b1;
        exp_q.push_back(brk_e);
        UART_RX = 1'b0;
        cyc(12 * 16);
        check_rx("break");
        check("break_busy", 16'(RX_Busy_Indicator), 16'd1);
        read_pulse();
        cyc(32);
        check("break_hold_valid", 16'(Data_Valid_Out), 16'd0);
        check("break_hold_busy", 16'(RX_Busy_Indicator), 16'd1);
        UART_RX = 1'b1;
        cyc(20);
        check("break_end_busy", 16'(RX_Busy_Indicator), 16'd0);
        check("break_end_valid", 16'(Data_Valid_Out), 16'd0);

        // Asynchronous reset in the middle of a frame
        send_frame(9'h03C, 8, 0, 1, 0, 0, 0, -1);
        check_rx("pre_reset");
        UART_RX = 1'b0;
        cyc(40);
        check("mid_busy", 16'(RX_Busy_Indicator), 16'd1);
        Reset_In = 1'b0;
        #1;
        check("arst_valid", 16'(Data_Valid_Out), 16'd0);
        check("arst_data", 16'(Data_Out), 16'd0);
        check("arst_busy", 16'(RX_Busy_Indicator), 16'd0);
        check("arst_flags", 16'({Parity_Error_Out, Framing_Error_Out, Overrun_Error_Out, Break_Detect_Out}), 16'd0);
        UART_RX = 1'b1;
        cyc(2);
        Reset_In = 1'b1;
        cyc(5);
        send_frame(9'h0A5, 8, 0, 1, 0, 0, 0, -1);
        check_rx("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Standalone UART receiver running on the system clock; recovers frames from a serial line using a 16x oversampling strobe from the baud rate generator.
- Counterpart to the transmit path of the UART devices: same frame options (5-9 data bits, optional even/odd parity, 1 or 2 stop bits).
- Adds majority-vote sampling, framing/parity/overrun/break detection and a one-deep holding register for the host.

Parameters:
- OVERSAMPLE, 16, sample strobes per bit; power of two, at least 8.
- SYNC_STAGES, 2, flip-flops in the RX input synchronizer.

Ports:
- Clk_In  input  1  system clock.
- Reset_In  input  1  asynchronous, active-low reset.
- Sample_Tick_In  input  1  one-Clk_In-cycle strobe at OVERSAMPLE x baud rate.
- UART_RX  input  1  serial line, idle high.
- UART_Num_Data_Bits_In  input  3  0=5, 1=6, 2=7, 3=8, 4=9 bits; values 5-7 are treated as 8.
- UART_Parity_Enable_In  input  1  1 = parity bit present.
- UART_Even_Oddb_Parity_In  input  1  1 = even, 0 = odd.
- UART_Num_Stop_Bits_In  input  1  0 = 1 stop bit, 1 = 2 stop bits.
- Data_Read_In  input  1  host pulse; clears Data_Valid_Out.
- Data_Out  output  9  received data, LSB-aligned, unused upper bits 0.
- Data_Valid_Out  output  1  holding register full.
- Parity_Error_Out  output  1  parity error flag for the word in Data_Out.
- Framing_Error_Out  output  1  a stop bit was sampled low.
- Overrun_Error_Out  output  1  a frame completed while Data_Valid_Out was high; sticky.
- Break_Detect_Out  output  1  break frame received.
- RX_Busy_Indicator  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronizer flops preset to 1.
- The FSM advances only on cycles where Sample_Tick_In=1. The tick counter tc runs 0..OVERSAMPLE-1.
- Bit value: majority of the synchronized samples at tc = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- IDLE: a synchronized 0 on a tick moves to START with tc=0. At that point the config inputs are latched; mid-frame config changes are ignored.
- START: at the mid-bit vote, 1 means a glitch (return to IDLE, no flags); 0 means continue. tc wraps at OVERSAMPLE-1 into DATA.
- DATA: data is received LSB first into a shift register. After N bits go to PARITY if enabled, else STOP1.
- PARITY: the received bit is compared with the XOR of the data bits. Even mode expects total ones even; odd mode expects total ones odd.
- STOP1: vote taken at mid-bit. If 2 stop bits, continue to STOP2 after the full bit; otherwise the frame completes at STOP1 mid-bit.
- STOP2: vote taken at mid-bit; the frame completes at this mid-bit.
- Frame completion: on the completing Clk_In edge, Data_Out, Parity_Error_Out, Framing_Error_Out and Break_Detect_Out load, and Data_Valid_Out=1. The FSM returns to IDLE immediately (mid-stop), so back-to-back frames are caught.
- Framing error: set if any stop vote is 0. The data is still delivered.
- Break: all data, parity and stop votes are 0. Break_Detect_Out=1, Framing_Error_Out=1 and Data_Out=0. The FSM then enters BREAK_WAIT and holds until one synchronized 1 is seen, then returns to IDLE.
- Overrun:
  - Completion while Data_Valid_Out=1: the new frame is discarded, the old Data_Out is kept and Overrun_Error_Out=1.
  - Overrun_Error_Out clears only on Data_Read_In or reset.
- Data_Read_In:
  - Clears Data_Valid_Out on the next edge.
  - If it coincides with a frame completion, the new frame is loaded, Data_Valid_Out stays 1 and there is no overrun.
  - Error flags follow the currently held word.
- Latency: Data_Valid_Out rises 1 Clk_In cycle after the last stop-bit mid-sample tick, plus SYNC_STAGES of input delay.
- Asynchronous reset mid-frame: the partial frame is discarded and the block returns to IDLE.

Decomposition:
- Shared package uart_pkg: the frame-config encodings (data-bit codes, parity and stop-bit meanings) and the FSM state enum, reused by the transmitter.
- One sub-module, uart_rx_sampler: synchronizer, tick counter and 3-sample majority vote. It outputs the voted bit and a mid-bit strobe.

Test Plan:
All tests use Sample_Tick_In=1 every cycle, so one bit is 16 Clk_In cycles.
- 8N1 0xA5 -> Data_Out=0x0A5, Data_Valid_Out=1, all error flags 0, RX_Busy_Indicator low after the stop mid-sample.
- 9-bit even parity 0x1C3 with correct parity bit 1 -> Data_Out=0x1C3, Parity_Error_Out=0. The same frame with parity bit 0 -> Parity_Error_Out=1.
- 7O2 0x55 with the second stop bit driven low -> Data_Out=0x055, Framing_Error_Out=1.
- 5-cycle low glitch on an idle line -> no Data_Valid_Out, FSM back to IDLE. A single-sample flip at a data-bit mid-sample -> majority vote still yields the correct byte.
- Two back-to-back 8N1 frames 0x11 then 0x22 with no Data_Read_In -> Data_Out=0x011, Overrun_Error_Out=1. Data_Read_In -> both flags clear.
- Line held low for 12 bit times in 8N1 -> Break_Detect_Out=1, Framing_Error_Out=1, Data_Out=0. No new frame until the line returns high. Reset_In asserted mid-frame -> all outputs 0 immediately.
